// File: rtl/led_fade_scheduler.sv
// Round-robin arbiter sharing one LED fader among four event requesters.
// Latency req->trigger 2 cycles; no backpressure, requests queue as pending bits until their fade and guard gap finish.
module led_fade_scheduler #(
    parameter int GAP_CYCLES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [95:0]  cor_req,
    input  logic [115:0] idx_req,
    input  logic         flush,
    output logic         fader_trigger,
    output logic [23:0]  fader_cor,
    output logic [28:0]  fader_max_idx,
    output logic [3:0]   grant,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_FADE, S_GAP} state_t;

    state_t      state;
    logic [3:0]  pend;
    logic [1:0]  ptr;
    logic [28:0] wcnt;
    logic [7:0]  gcnt;

    logic        win_vld;
    logic [1:0]  win;
    logic [1:0]  cand;
    logic [3:0]  win_oh;
    logic [23:0] win_cor;
    logic [28:0] win_idx;
    logic [27:0] win_len;
    logic [28:0] wload;
    logic [3:0]  clr;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win     = ptr;
        cand    = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (pend[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        win_cor = cor_req[23:0];
        win_idx = idx_req[28:0];
        for (int i = 0; i < 4; i++) begin
            if (win == 2'(i)) begin
                win_cor = cor_req[24*i +: 24];
                win_idx = idx_req[29*i +: 29];
            end
        end
    end

    // Fade must last until the fader output is black: L = max(1, idx/2), plus two cycles of pipeline.
    assign win_oh  = 4'b0001 << win;
    assign win_len = (win_idx[28:1] == 28'd0) ? 28'd1 : win_idx[28:1];
    assign wload   = {1'b0, win_len} + 29'd2;
    assign clr     = (state == S_IDLE && win_vld) ? win_oh : 4'b0000;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            pend          <= 4'b0000;
            ptr           <= 2'd0;
            wcnt          <= 29'd0;
            gcnt          <= 8'd0;
            fader_trigger <= 1'b0;
            grant         <= 4'b0000;
            fader_cor     <= 24'd0;
            fader_max_idx <= 29'd0;
        end else begin
            fader_trigger <= 1'b0;
            grant         <= 4'b0000;
            if (flush) begin
                state <= S_IDLE;
                pend  <= 4'b0000;
            end else begin
                pend <= (pend & ~clr) | req;
                case (state)
                    S_IDLE: begin
                        if (win_vld) begin
                            fader_trigger <= 1'b1;
                            grant         <= win_oh;
                            fader_cor     <= win_cor;
                            fader_max_idx <= win_idx;
                            wcnt          <= wload;
                            ptr           <= win + 2'd1;
                            state         <= S_FADE;
                        end
                    end
                    S_FADE: begin
                        wcnt <= wcnt - 29'd1;
                        if (wcnt == 29'd1) begin
                            if (GAP_CYCLES == 0) begin
                                state <= S_IDLE;
                            end else begin
                                gcnt  <= 8'(GAP_CYCLES);
                                state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        gcnt <= gcnt - 8'd1;
                        if (gcnt == 8'd1) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_fade_scheduler.sv
// Runs a GAP_CYCLES=2 and a GAP_CYCLES=0 scheduler on shared stimulus against a per-instance
// model that tracks pending bits, pointer and the cycle at which each scheduler is next free.
module tb_led_fade_scheduler;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [95:0]  cor_req = '0;
    logic [115:0] idx_req = '0;
    logic         flush = 1'b0;

    logic [1:0]   o_trig;
    logic [1:0]   o_busy;
    logic [23:0]  o_cor [2];
    logic [28:0]  o_idx [2];
    logic [3:0]   o_grant [2];

    led_fade_scheduler #(.GAP_CYCLES(2)) u_gap2 (
        .clock(clock), .reset(reset), .req(req), .cor_req(cor_req), .idx_req(idx_req),
        .flush(flush), .fader_trigger(o_trig[0]), .fader_cor(o_cor[0]),
        .fader_max_idx(o_idx[0]), .grant(o_grant[0]), .busy(o_busy[0])
    );

    led_fade_scheduler #(.GAP_CYCLES(0)) u_gap0 (
        .clock(clock), .reset(reset), .req(req), .cor_req(cor_req), .idx_req(idx_req),
        .flush(flush), .fader_trigger(o_trig[1]), .fader_cor(o_cor[1]),
        .fader_max_idx(o_idx[1]), .grant(o_grant[1]), .busy(o_busy[1])
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    longint cyc = 0;
    int gap [2] = '{2, 0};

    logic [3:0]  m_pend [2];
    int          m_ptr [2];
    longint      m_free [2];
    logic        e_trig [2];
    logic [3:0]  e_grant [2];
    logic [23:0] e_cor [2];
    logic [28:0] e_idx [2];
    logic        e_busy [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 4'b0000; m_ptr[d] = 0; m_free[d] = 0;
            e_trig[d] = 1'b0; e_grant[d] = 4'b0000; e_cor[d] = '0; e_idx[d] = '0; e_busy[d] = 1'b0;
        end
    endtask

    // Called with the inputs of cycle cyc; leaves expectations for cycle cyc+1.
    task automatic model_step(input logic [3:0] r, input logic f);
        int w;
        longint len;
        for (int d = 0; d < 2; d++) begin
            e_trig[d] = 1'b0;
            e_grant[d] = 4'b0000;
            if (f) begin
                m_pend[d] = 4'b0000;
                m_free[d] = cyc + 1;
            end else begin
                if (cyc >= m_free[d] && m_pend[d] != 4'b0000) begin
                    w = -1;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && m_pend[d][(m_ptr[d] + k) % 4]) w = (m_ptr[d] + k) % 4;
                    e_trig[d] = 1'b1;
                    e_grant[d] = 4'(1 << w);
                    e_cor[d] = cor_req[24*w +: 24];
                    e_idx[d] = idx_req[29*w +: 29];
                    len = longint'(e_idx[d]) / 2;
                    if (len < 1) len = 1;
                    m_free[d] = cyc + 1 + len + 2 + gap[d];
                    m_ptr[d] = (w + 1) % 4;
                    m_pend[d][w] = 1'b0;
                end
                m_pend[d] = m_pend[d] | r;
            end
            e_busy[d] = (cyc + 1 < m_free[d]);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_trigger", d), 64'(o_trig[d]), 64'(e_trig[d]));
            chk($sformatf("d%0d_grant", d), 64'(o_grant[d]), 64'(e_grant[d]));
            chk($sformatf("d%0d_busy", d), 64'(o_busy[d]), 64'(e_busy[d]));
            chk($sformatf("d%0d_cor", d), 64'(o_cor[d]), 64'(e_cor[d]));
            chk($sformatf("d%0d_max_idx", d), 64'(o_idx[d]), 64'(e_idx[d]));
        end
    endtask

    task automatic step(input logic [3:0] r, input logic f);
        @(negedge clock);
        req = r;
        flush = f;
        model_step(r, f);
        @(posedge clock);
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
    endtask

    task automatic set_all(input logic [23:0] c, input logic [28:0] x);
        for (int i = 0; i < 4; i++) begin
            cor_req[24*i +: 24] = c ^ 24'(i * 24'h010101);
            idx_req[29*i +: 29] = x;
        end
    endtask

    initial begin
        model_reset();
        req = 4'b1111;
        set_all(24'hABCDEF, 29'd9);
        @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
        req = 4'b0000;

        // Single request, colour FF8000 and duration 10 from requester 0.
        set_all(24'h123456, 29'd7);
        cor_req[23:0] = 24'hFF8000;
        idx_req[28:0] = 29'd10;
        step(4'b0001, 1'b0);
        idle(14);

        // All four at once, duration 4 each: strict rotation.
        set_all(24'h00FF00, 29'd4);
        step(4'b1111, 1'b0);
        idle(32);

        // Grant requester 2, then 0 and 2 together: 0 must go first.
        step(4'b0100, 1'b0);
        idle(3);
        step(4'b0101, 1'b0);
        idle(22);

        // Requester 1 re-requests on its grant edge, then on its trigger cycle.
        set_all(24'h0000FF, 29'd3);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        idle(20);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b0);
        idle(20);

        // Zero duration from requester 3, re-requested while its fade runs.
        set_all(24'hFFFFFF, 29'd0);
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b1000, 1'b0);
        idle(16);

        // Flush mid-fade with 1 and 3 pending; a simultaneous request is dropped.
        set_all(24'h445566, 29'd20);
        step(4'b0010, 1'b0);
        idle(2);
        step(4'b1010, 1'b0);
        idle(2);
        step(4'b0101, 1'b1);
        idle(10);

        // Widest duration reaches the fader unchanged; flush ends the long fade.
        set_all(24'h808080, 29'h1FFF_FFFF);
        step(4'b0001, 1'b0);
        idle(6);
        step(4'b0000, 1'b1);
        idle(3);

        // Randomised traffic with occasional flushes.
        for (int n = 0; n < 900; n++) begin
            for (int i = 0; i < 4; i++) begin
                cor_req[24*i +: 24] = 24'($urandom);
                idx_req[29*i +: 29] = 29'($urandom_range(0, 12));
            end
            step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, ($urandom_range(0, 59) == 0));
        end
        idle(30);

        // Asynchronous reset in the middle of a fade.
        set_all(24'h13579B, 29'd20);
        step(4'b0001, 1'b0);
        idle(4);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
        step(4'b0100, 1'b0);
        idle(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
